memory_bus_responder: RTL and testbench
=======================================

// Module: memory_bus_responder
// PURPOSE
// - Target end of the CPU memory bus. Sits between the core's address/data/R-W outputs and its data input.
// - Decodes each bus cycle to one of three targets: on-chip RAM, a 16-byte I/O window, or unmapped space.
// - I/O window holds an output port, a byte-stream TX FIFO, a status register and a free-running 16-bit timer.
// PARAMETERS
// - RAM_ADDR_WIDTH  12        RAM size = 2**RAM_ADDR_WIDTH bytes, mapped at 0x0000.
// - IO_BASE         16'hD000  Base of the I/O window (16 bytes, IO_BASE[3:0] must be 0).
// - FIFO_DEPTH      8         TX FIFO entries (power of 2, >= 2).
// PORTS
// - clk         in   1   System clock; all state updates on its rising edge.
// - reset       in   1   Synchronous, active-high reset.
// - read_write  in   1   Bus direction from CPU: 0 = read, 1 = write.
// - address     in   16  Bus address from CPU.
// - wdata       in   8   Write data from CPU (data_out of the core).
// - rdata       out  8   Read data to CPU (data_in of the core).
// - out_port    out  8   General-purpose output register.
// - tx_data     out  8   TX FIFO head byte.
// - tx_valid    out  1   TX FIFO non-empty.
// - tx_ready    in   1   Downstream consumer accepts tx_data this cycle.
// BEHAVIOUR
// - Every clock cycle is one bus cycle; no stalls, no wait states.
// - Decode: RAM if address < 2**RAM_ADDR_WIDTH; IO if address[15:4] == IO_BASE[15:4]; all other addresses are unmapped.
// - RAM cannot also overlap IO; the region check is done on the full 16-bit address.
// - Write (read_write=1): target updated at the rising edge ending the cycle. Unmapped writes are ignored.
// - Read (read_write=0): rdata is registered. Address is sampled at edge N; data is valid from edge N to edge N+1 (1-cycle latency).
// - rdata holds its last value during write cycles.
// - Unmapped read returns 8'hFF. RAM reads return the stored byte; RAM contents are not cleared by reset.
// - IO map (offset = address[3:0]):
//   - 0 OUT_PORT: R/W; read returns out_port.
//   - 1 TX_DATA: W pushes wdata into the FIFO; read returns 8'h00.
//   - 2 STATUS: R = {5'b0, ovf, full, empty}; any write clears ovf.
//   - 3 TIMER_LO: R returns timer[7:0] and copies timer[15:8] into the shadow register in the same edge.
//   - 4 TIMER_HI: R returns the shadow register.
//   - 5..15: read 8'h00, writes ignored.
// - Timer: increments by 1 every cycle and wraps 16'hFFFF -> 16'h0000. The value read is the value before that edge's increment.
// - FIFO handshake: pop when tx_valid && tx_ready; tx_data is the head byte, stable while tx_valid=1 and not popped.
// - Push with FIFO not full: accepted. Push when full with a pop in the same cycle: accepted, count unchanged.
// - Push when full with no pop: byte dropped and ovf set (sticky).
// - Simultaneous push and pop on a non-empty FIFO: count unchanged, order preserved.
// - Push on an empty FIFO: tx_valid rises the next cycle; there is no same-cycle fall-through.
// - Read and write pointers wrap modulo FIFO_DEPTH. full = (count == FIFO_DEPTH); empty = (count == 0).
// - A STATUS write that clears ovf and a same-cycle overflow cannot coincide: they are different offsets within one cycle.
// - Reset (any cycle, including mid-stream) sets:
//   - rdata = 0, out_port = 0, tx_valid = 0, tx_data = 0
//   - FIFO empty, pointers = 0, ovf = 0
//   - timer = 0, shadow = 0
//   Any transfer in progress is discarded.
// TESTING
// - RAM: write 0x0123 <- 0x5A, read 0x0123 -> rdata = 0x5A one cycle later. Read 0x8000 -> 0xFF; write 0x8000 has no effect.
// - OUT_PORT: write 0xD000 <- 0xC3 -> out_port = 0xC3 after the edge; reading 0xD000 returns 0xC3; reset -> out_port = 0x00.
// - FIFO: tx_ready=0, push 0x11..0x18 (8 bytes) -> STATUS = 0x02. Push 0x99 -> STATUS = 0x06.
//   Raise tx_ready -> tx_data 0x11..0x18 in order, then tx_valid=0. Write STATUS -> 0x01.
// - Full FIFO plus push 0xAA with tx_ready=1 in the same cycle -> no ovf; 0xAA emerges 9th overall.
// - Timer: at reset release, read TIMER_LO at cycle 0x01FE -> 0xFE; TIMER_HI a few cycles later -> 0x01 (shadow, not live).
//   Let the timer pass 0xFFFF -> reads wrap to 0x0000.
// - Reset asserted with 3 bytes queued and tx_ready=0 -> tx_valid = 0, STATUS = 0x01, timer read = 0x0000 on the first cycle after reset.

Source files
------------

// File: rtl/memory_bus_responder.sv
// rtl/memory_bus_responder.sv - CPU bus target: RAM, I/O window (out port, TX FIFO, status, timer), unmapped space
module memory_bus_responder #(
  parameter int          RAM_ADDR_WIDTH = 12,
  parameter logic [15:0] IO_BASE        = 16'hD000,
  parameter int          FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_write,
  input  logic [15:0] address,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic [7:0]  out_port,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAM_SIZE = 2 ** RAM_ADDR_WIDTH;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [3:0] OFF_OUT_PORT = 4'h0;
  localparam logic [3:0] OFF_TX_DATA  = 4'h1;
  localparam logic [3:0] OFF_STATUS   = 4'h2;
  localparam logic [3:0] OFF_TIMER_LO = 4'h3;
  localparam logic [3:0] OFF_TIMER_HI = 4'h4;

  logic [7:0]       ram [RAM_SIZE];
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             ovf;
  logic [15:0]      timer;
  logic [7:0]       shadow;

  logic             is_ram, is_io;
  logic [3:0]       io_off;
  logic             fifo_full, fifo_empty;
  logic             push, pop, push_ok, push_drop, status_wr, timer_lo_rd;
  logic [7:0]       status;
  logic [7:0]       rd_val;

  always_comb begin
    is_ram      = (address[15:RAM_ADDR_WIDTH] == '0);
    is_io       = (address[15:4] == IO_BASE[15:4]);
    io_off      = address[3:0];
    fifo_full   = (count == FULL_COUNT);
    fifo_empty  = (count == '0);
    tx_valid    = !fifo_empty;
    tx_data     = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
    pop         = tx_valid && tx_ready;
    push        = read_write && is_io && (io_off == OFF_TX_DATA);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok     = push && (!fifo_full || pop);
    push_drop   = push && fifo_full && !pop;
    status_wr   = read_write && is_io && (io_off == OFF_STATUS);
    timer_lo_rd = !read_write && is_io && (io_off == OFF_TIMER_LO);
    status      = {5'b0, ovf, fifo_full, fifo_empty};
  end

  always_comb begin
    rd_val = 8'hFF;
    if (is_ram) begin
      rd_val = ram[address[RAM_ADDR_WIDTH-1:0]];
    end else if (is_io) begin
      case (io_off)
        OFF_OUT_PORT: rd_val = out_port;
        OFF_STATUS:   rd_val = status;
        OFF_TIMER_LO: rd_val = timer[7:0];
        OFF_TIMER_HI: rd_val = shadow;
        default:      rd_val = 8'h00;
      endcase
    end
  end

  // Storage arrays carry no reset; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (!reset && read_write && is_ram)
      ram[address[RAM_ADDR_WIDTH-1:0]] <= wdata;
    if (!reset && push_ok)
      fifo_mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= 8'h00;
      out_port <= 8'h00;
      ovf      <= 1'b0;
      timer    <= 16'h0000;
      shadow   <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      timer <= timer + 16'h0001;
      if (!read_write)
        rdata <= rd_val;
      if (timer_lo_rd)
        shadow <= timer[15:8];
      if (read_write && is_io && (io_off == OFF_OUT_PORT))
        out_port <= wdata;
      if (status_wr)
        ovf <= 1'b0;
      else if (push_drop)
        ovf <= 1'b1;
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus_responder.sv
// tb/tb_memory_bus_responder.sv - directed self-checking bench for memory_bus_responder
module tb_memory_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_write;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [7:0]  out_port;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int          total = 0;
  int          bad = 0;
  logic [15:0] tcount;

  memory_bus_responder dut (
    .clk        (clk),
    .reset      (reset),
    .read_write (read_write),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .out_port   (out_port),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  always #5 clk = ~clk;

  // One bus cycle; returns 1 time unit after the edge that ends it.
  task automatic cycle(input logic rw, input logic [15:0] a, input logic [7:0] d);
    read_write = rw;
    address    = a;
    wdata      = d;
    @(posedge clk);
    #1;
    tcount = tcount + 16'h0001;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 16'h8000, 8'h00);
    reset = 1'b0;
    tcount = 16'h0000;
  endtask

  task automatic test_reset();
    tx_ready = 1'b0;
    do_reset();
    do_reset();
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    total++; if (out_port !== 8'h00) begin bad++; $display("FAIL reset_out_port: got %h want 00", out_port); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    cycle(1'b0, 16'hD002, 8'h00);
    total++; if (rdata !== 8'h01) begin bad++; $display("FAIL reset_status: got %h want 01", rdata); end
  endtask

  task automatic test_ram();
    cycle(1'b1, 16'h0123, 8'h5A);
    cycle(1'b0, 16'h0123, 8'h00);
    total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL ram_read: got %h want 5a", rdata); end
    cycle(1'b1, 16'h0124, 8'h33);
    total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL rdata_hold_on_write: got %h want 5a", rdata); end
    cycle(1'b0, 16'h8000, 8'h00);
    total++; if (rdata !== 8'hFF) begin bad++; $display("FAIL unmapped_read: got %h want ff", rdata); end
    cycle(1'b1, 16'h8000, 8'h12);
    cycle(1'b1, 16'h1123, 8'h77);
    cycle(1'b0, 16'h8000, 8'h00);
    total++; if (rdata !== 8'hFF) begin bad++; $display("FAIL unmapped_write_ignored: got %h want ff", rdata); end
    cycle(1'b0, 16'h0123, 8'h00);
    total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL ram_no_alias: got %h want 5a", rdata); end
    cycle(1'b0, 16'h0124, 8'h00);
    total++; if (rdata !== 8'h33) begin bad++; $display("FAIL ram_read2: got %h want 33", rdata); end
  endtask

  task automatic test_out_port();
    cycle(1'b1, 16'hD000, 8'hC3);
    total++; if (out_port !== 8'hC3) begin bad++; $display("FAIL out_port_write: got %h want c3", out_port); end
    cycle(1'b0, 16'hD000, 8'h00);
    total++; if (rdata !== 8'hC3) begin bad++; $display("FAIL out_port_read: got %h want c3", rdata); end
    cycle(1'b1, 16'hD005, 8'h44);
    cycle(1'b0, 16'hD005, 8'h00);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL io_reserved_read: got %h want 00", rdata); end
    cycle(1'b0, 16'hD001, 8'h00);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL tx_data_reg_read: got %h want 00", rdata); end
  endtask

  task automatic test_fifo();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'hD001, 8'h11 + 8'(i));
      if (i == 0) begin
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL tx_valid_after_push: got %b want 1", tx_valid); end
      end
    end
    cycle(1'b0, 16'hD002, 8'h00);
    total++; if (rdata !== 8'h02) begin bad++; $display("FAIL status_full: got %h want 02", rdata); end
    cycle(1'b1, 16'hD001, 8'h99);
    cycle(1'b0, 16'hD002, 8'h00);
    total++; if (rdata !== 8'h06) begin bad++; $display("FAIL status_ovf: got %h want 06", rdata); end
    total++; if (tx_data !== 8'h11) begin bad++; $display("FAIL head_stable: got %h want 11", tx_data); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h11 + 8'(i)) begin
        bad++; $display("FAIL drain_order[%0d]: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'h11 + 8'(i));
      end
      cycle(1'b0, 16'h8000, 8'h00);
    end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL drained_empty: got %b want 0", tx_valid); end
    tx_ready = 1'b0;
    cycle(1'b0, 16'hD002, 8'h00);
    total++; if (rdata !== 8'h05) begin bad++; $display("FAIL status_empty_ovf: got %h want 05", rdata); end
    cycle(1'b1, 16'hD002, 8'h00);
    cycle(1'b0, 16'hD002, 8'h00);
    total++; if (rdata !== 8'h01) begin bad++; $display("FAIL status_ovf_cleared: got %h want 01", rdata); end
  endtask

  task automatic test_full_push_pop();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'hD001, 8'h21 + 8'(i));
    tx_ready = 1'b1;
    cycle(1'b1, 16'hD001, 8'hAA);
    tx_ready = 1'b0;
    cycle(1'b0, 16'hD002, 8'h00);
    total++; if (rdata !== 8'h02) begin bad++; $display("FAIL full_push_pop_status: got %h want 02", rdata); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp;
      exp = (i == 7) ? 8'hAA : 8'h22 + 8'(i);
      total++;
      if (tx_valid !== 1'b1 || tx_data !== exp) begin
        bad++; $display("FAIL full_push_pop_order[%0d]: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp);
      end
      cycle(1'b0, 16'h8000, 8'h00);
    end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL full_push_pop_empty: got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_timer();
    do_reset();
    while (tcount != 16'h01FE) cycle(1'b0, 16'h8000, 8'h00);
    cycle(1'b0, 16'hD003, 8'h00);
    total++; if (rdata !== 8'hFE) begin bad++; $display("FAIL timer_lo: got %h want fe", rdata); end
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h8000, 8'h00);
    cycle(1'b0, 16'hD004, 8'h00);
    total++; if (rdata !== 8'h01) begin bad++; $display("FAIL timer_hi_shadow: got %h want 01", rdata); end
    while (tcount != 16'hFFFF) cycle(1'b0, 16'h8000, 8'h00);
    cycle(1'b0, 16'hD003, 8'h00);
    total++; if (rdata !== 8'hFF) begin bad++; $display("FAIL timer_lo_ffff: got %h want ff", rdata); end
    cycle(1'b0, 16'hD003, 8'h00);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL timer_lo_wrap: got %h want 00", rdata); end
    cycle(1'b0, 16'hD004, 8'h00);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL timer_hi_wrap: got %h want 00", rdata); end
  endtask

  task automatic test_reset_midstream();
    tx_ready = 1'b0;
    cycle(1'b1, 16'hD000, 8'h5C);
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'hD001, 8'h61 + 8'(i));
    cycle(1'b0, 16'hD000, 8'h00);
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL mid_queued: got %b want 1", tx_valid); end
    do_reset();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_tx_valid: got %b want 0", tx_valid); end
    total++; if (out_port !== 8'h00) begin bad++; $display("FAIL mid_reset_out_port: got %h want 00", out_port); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL mid_reset_rdata: got %h want 00", rdata); end
    cycle(1'b0, 16'hD003, 8'h00);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL mid_reset_timer: got %h want 00", rdata); end
    cycle(1'b0, 16'hD002, 8'h00);
    total++; if (rdata !== 8'h01) begin bad++; $display("FAIL mid_reset_status: got %h want 01", rdata); end
  endtask

  initial begin
    reset      = 1'b1;
    read_write = 1'b0;
    address    = 16'h8000;
    wdata      = 8'h00;
    tx_ready   = 1'b0;
    tcount     = 16'h0000;
    #2;
    test_reset();
    test_ram();
    test_out_port();
    test_fifo();
    test_full_push_pop();
    test_timer();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
